// File: rtl/mem_pkg.sv
// Shared address-field widths, defaults and FSM state encoding for mem_arbiter.
// Pure declarations: no latency, no flow control.
// Consumers import mem_pkg::* and override defaults through parameters.
package mem_pkg;

    localparam int TAG_W         = 3;
    localparam int INDEX_W       = 10;
    localparam int OFFSET_W      = 2;
    localparam int ADDR_W        = TAG_W + INDEX_W + OFFSET_W;
    localparam int DATA_W        = 32;
    localparam int REFILL_CYCLES = 2;
    localparam int MAX_RETRY     = 3;
    localparam int CNT_W         = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        CHECK  = 3'd2,
        REFILL = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and statistics signals of mem_arbiter in one bundle.
// slave = arbiter side; master = requesters plus memory model.
// Requests are held until ack; the memory answers through hit/miss flags.
interface mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);

    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_dataout;
    logic              mem_hit;
    logic              mem_miss;
    logic              busy;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  req0, addr0, req1, addr1,
        input  mem_dataout, mem_hit, mem_miss,
        output ack0, ack1, rdata, err, mem_address,
        output busy, hit_count, miss_count
    );

    modport master (
        output req0, addr0, req1, addr1,
        output mem_dataout, mem_hit, mem_miss,
        input  ack0, ack1, rdata, err, mem_address,
        input  busy, hit_count, miss_count
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last served requester loses a tie.
// Latency: grant is combinational from req; last_grant updates on upd_vld_i.
// No backpressure: the caller decides when a grant is taken.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic upd_vld_i,
    input  logic upd_id_i,
    output logic gnt_vld_o,
    output logic gnt_id_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (upd_vld_i) begin
            last_d = upd_id_i;
        end
    end

    // Reset value 1 gives requester 0 the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt_vld_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_id_o = ~last_q;
        end else begin
            gnt_id_o = req1_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sequencing one cached read per grant with refill retries.
// Latency: hit acks 3 cycles after the granting IDLE cycle; +REFILL_CYCLES+2 per miss.
// Requests hold until ack; new requests wait for IDLE, no preemption.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W        = mem_pkg::ADDR_W,
    parameter int DATA_W        = mem_pkg::DATA_W,
    parameter int REFILL_CYCLES = mem_pkg::REFILL_CYCLES,
    parameter int MAX_RETRY     = mem_pkg::MAX_RETRY,
    parameter int CNT_W         = mem_pkg::CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam int WAIT_W  = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(REFILL_CYCLES);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [WAIT_W-1:0]  wait_q,  wait_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   hit_q,   hit_d;
    logic [CNT_W-1:0]   miss_q,  miss_d;

    logic               gnt_vld;
    logic               gnt_id;
    logic               resp_vld;
    logic [RETRY_W-1:0] retry_inc;

    assign resp_vld  = (state_q == RESP);
    assign retry_inc = retry_q + RETRY_W'(1);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .req0_i    (bus.req0),
        .req1_i    (bus.req1),
        .upd_vld_i (resp_vld),
        .upd_id_i  (owner_q),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        retry_d = retry_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        hit_d   = hit_q;
        miss_d  = miss_q;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_id;
                    addr_d  = gnt_id ? bus.addr1 : bus.addr0;
                    retry_d = '0;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                state_d = CHECK;
            end

            CHECK: begin
                // Hit takes precedence when the memory raises both flags.
                if (bus.mem_hit) begin
                    rdata_d = bus.mem_dataout;
                    err_d   = 1'b0;
                    if ((retry_q == '0) && (hit_q != '1)) begin
                        hit_d = hit_q + CNT_W'(1);
                    end
                    state_d = RESP;
                end else if (bus.mem_miss) begin
                    if (miss_q != '1) begin
                        miss_d = miss_q + CNT_W'(1);
                    end
                    retry_d = retry_inc;
                    if (retry_inc > RETRY_LIM) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (REFILL_CYCLES == 0) begin
                        state_d = ISSUE;
                    end else begin
                        wait_d  = WAIT_LOAD;
                        state_d = REFILL;
                    end
                end
            end

            REFILL: begin
                // Stays exactly REFILL_CYCLES cycles; address is left untouched.
                wait_d = wait_q - WAIT_W'(1);
                if (wait_q <= WAIT_W'(1)) begin
                    state_d = ISSUE;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            retry_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            retry_q <= retry_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.ack0        = resp_vld && !owner_q;
    assign bus.ack1        = resp_vld &&  owner_q;
    assign bus.rdata       = rdata_q;
    assign bus.err         = err_q;
    assign bus.mem_address = addr_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.hit_count   = hit_q;
    assign bus.miss_count  = miss_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester round-robin arbiter that shares the cache-backed memory subsystem, with its 15-bit address, 32-bit data out and hit/miss flags.
Each grant sequences one read transaction: drive the address, check hit or miss, wait out the refill on a miss, re-check, then return data with a one-cycle ack.
Keeps saturating hit/miss statistics and flags a transaction that never hits.
Sits between the core-side requesters and the memory top level.

Parameters:
ADDR_W, 15, address width (3-bit tag, 10-bit index, 2-bit word offset)
DATA_W, 32, read data width
REFILL_CYCLES, 2, wait cycles after a miss before re-checking (block write into the cache)
MAX_RETRY, 3, misses tolerated per transaction before an error response
CNT_W, 16, statistics counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req0  input  1  requester 0 read request, held until ack0
addr0  input  ADDR_W  requester 0 address, stable while req0 is high
req1  input  1  requester 1 read request, held until ack1
addr1  input  ADDR_W  requester 1 address
ack0  output  1  one-cycle pulse: rdata/err valid for requester 0
ack1  output  1  one-cycle pulse for requester 1
rdata  output  DATA_W  registered read data, shared by both requesters
err  output  1  qualifies ack: retry limit exceeded, rdata=0
mem_address  output  ADDR_W  address to memory, registered
mem_dataout  input  DATA_W  memory read data
mem_hit  input  1  memory hit flag for mem_address
mem_miss  input  1  memory miss flag for mem_address
busy  output  1  high in any state except IDLE
hit_count  output  CNT_W  saturating count of transactions that hit on first check
miss_count  output  CNT_W  saturating count of miss events (every CHECK that saw a miss)

Behaviour:
- Reset (async, immediate): state=IDLE, ack0=ack1=0, err=0, rdata=0, mem_address=0, busy=0, counters=0, last_grant=1 (requester 0 has priority first).
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - On grant: latch owner, mem_address<=addrN, retry<=0, go ISSUE.
- ISSUE: one cycle for the memory to settle on the new address; go CHECK.
- CHECK, first match wins:
  - mem_hit: rdata<=mem_dataout, err<=0. If retry==0, hit_count++. Go RESP.
  - mem_miss: miss_count++, retry++. If the new retry exceeds MAX_RETRY: rdata<=0, err<=1, go RESP. Otherwise load wait counter with REFILL_CYCLES and go REFILL.
  - Neither flag set: stay in CHECK (no timeout).
  - Both flags set: treat as hit.
- REFILL: decrement the wait counter each cycle. At 0 go ISSUE; the address is unchanged.
- RESP: ackN=1 for owner only, for exactly one cycle. last_grant<=owner. Go IDLE. rdata/err hold until the next RESP.
- Latency:
  - Hit: grant cycle + ISSUE + CHECK + RESP, so ack appears 3 cycles after the IDLE cycle that saw req.
  - Each miss adds 1+REFILL_CYCLES+1 cycles.
- A requester must drop req the cycle after ack. A req still high in IDLE is a new request.
- Simultaneous new request during a transaction: ignored until IDLE. No preemption.
- Counters saturate at all-ones; no wrap.
- Reset mid-transaction: everything aborts to reset values and no ack is issued. Requesters re-request.
- mem_address changes only on grant, so the memory sees a stable address throughout retries.

Decomposition:
- Shared package mem_pkg: address field widths (TAG_W=3, INDEX_W=10, OFFSET_W=2), DATA_W, and the state enum (IDLE, ISSUE, CHECK, REFILL, RESP).
- One natural sub-module: rr_arb2, the two-way round-robin grant with last_grant register.
- Statistics counters stay inline.

Test Plan:
- Single hit: req0, addr0=15'h0123, memory model hits with data 32'hDEADBEEF → ack0 3 cycles later, rdata=32'hDEADBEEF, err=0, hit_count=1, miss_count=0.
- Miss then hit: req1, addr1=15'h7FFC, miss on first check, hit after refill → ack1 at cycle 3+1+REFILL_CYCLES+1=7, hit_count=0, miss_count=1.
- Both requesting continuously after reset → grants alternate 0,1,0,1; no requester is starved; each ack is exactly one cycle.
- Persistent miss: memory always misses, MAX_RETRY=3 → 4 CHECKs, then ack0 with err=1, rdata=0, miss_count=4.
- Async reset asserted in REFILL → outputs reset immediately (mid-cycle), no ack. After release, a new req0 completes normally.
- Saturation: preload via 2^CNT_W hits (or reduced CNT_W=4 build) → hit_count holds at 4'hF.
